qkv_proj_seq: RTL and testbench

- Upstream neighbour of the fused attention + LayerNorm stage.
- Accepts one SEQ_LEN x EMBED_DIM token frame X and produces Q = X·Wq, K = X·Wk, V = X·Wv, which feed the attention stage directly.
- Weights live in internal register files, loaded through a write port.
- Computation is time-multiplexed: three MAC units (one each for Q, K, V), each doing one product per cycle.

---
 rtl/qkv_proj_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_qkv_proj_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qkv_proj_seq.sv
// Purpose : projects one SEQ_LEN x EMBED_DIM token frame X into Q/K/V with three time-multiplexed MACs.
// Latency : valid_out rises 257 cycles after the accept edge (256 MAC cycles plus one to raise valid_out).
// Backpres: one frame in flight; ready_in low in MAC/DONE, results held in DONE until ready_out.
// Optional: define QKV_PROJ_BIAS_EN to add per-column bias vectors (written with w_sel=3).
module qkv_proj_seq #(
    parameter int SEQ_LEN   = 4,
    parameter int EMBED_DIM = 8,
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 40,
    parameter int FRAC_W    = 8
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          w_we,
    input  logic [1:0]                                    w_sel,
    input  logic [$clog2(EMBED_DIM)-1:0]                  w_row,
    input  logic [$clog2(EMBED_DIM)-1:0]                  w_col,
    input  logic [DATA_W-1:0]                             w_data,
    input  logic                                          valid_in,
    output logic                                          ready_in,
    input  logic [SEQ_LEN-1:0][EMBED_DIM-1:0][DATA_W-1:0] X,
    output logic                                          valid_out,
    input  logic                                          ready_out,
    output logic [SEQ_LEN-1:0][EMBED_DIM-1:0][DATA_W-1:0] Q,
    output logic [SEQ_LEN-1:0][EMBED_DIM-1:0][DATA_W-1:0] K,
    output logic [SEQ_LEN-1:0][EMBED_DIM-1:0][DATA_W-1:0] V,
    output logic                                          busy
);

    localparam int TW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int EW = $clog2(EMBED_DIM);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((longint'(1) <<< (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t state, state_nxt;

    // Captured frame and weight register files, indexed [row r][column c]
    logic [SEQ_LEN-1:0][EMBED_DIM-1:0][DATA_W-1:0]   xf;
    logic [EMBED_DIM-1:0][EMBED_DIM-1:0][DATA_W-1:0] wq, wk, wv;

    logic [TW-1:0] t_cnt;
    logic [EW-1:0] c_cnt, r_cnt;
    logic          t_last, c_last, r_last;

    logic signed [ACC_W-1:0]    acc_q, acc_k, acc_v;
    logic signed [ACC_W-1:0]    sum_q, sum_k, sum_v;
    logic signed [2*DATA_W-1:0] prod_q, prod_k, prod_v;
    logic [DATA_W-1:0]          bias_q_sel, bias_k_sel, bias_v_sel;

    assign t_last = (t_cnt == TW'(SEQ_LEN - 1));
    assign c_last = (c_cnt == EW'(EMBED_DIM - 1));
    assign r_last = (r_cnt == EW'(EMBED_DIM - 1));

    // Floor-shift the accumulated sum, add the bias term, then clamp to the signed output range
    function automatic logic [DATA_W-1:0] scale_sat(input logic signed [ACC_W-1:0] acc,
                                                    input logic [DATA_W-1:0] bias);
        logic signed [ACC_W-1:0] y;
        y = (acc >>> FRAC_W) + ACC_W'($signed(bias));
        if (y > SAT_MAX) begin
            return SAT_MAX[DATA_W-1:0];
        end else if (y < SAT_MIN) begin
            return SAT_MIN[DATA_W-1:0];
        end
        return y[DATA_W-1:0];
    endfunction

`ifdef QKV_PROJ_BIAS_EN
    logic [EMBED_DIM-1:0][DATA_W-1:0] bias_q, bias_k, bias_v;

    // Bias vectors share the weight write port; writes are frozen while a frame is in MAC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_q <= '0;
            bias_k <= '0;
            bias_v <= '0;
        end else if (w_we && (w_sel == 2'd3) && (state != MAC)) begin
            case (w_row)
                EW'(0):  bias_q[w_col] <= w_data;
                EW'(1):  bias_k[w_col] <= w_data;
                EW'(2):  bias_v[w_col] <= w_data;
                default: ;
            endcase
        end
    end

    // Bias for the output column currently being produced
    always_comb begin
        bias_q_sel = bias_q[c_cnt];
        bias_k_sel = bias_k[c_cnt];
        bias_v_sel = bias_v[c_cnt];
    end
`else
    assign bias_q_sel = '0;
    assign bias_k_sel = '0;
    assign bias_v_sel = '0;
`endif

    // One full-precision product per MAC per cycle, sign-extended into the running sum
    always_comb begin
        prod_q = $signed(xf[t_cnt][r_cnt]) * $signed(wq[r_cnt][c_cnt]);
        prod_k = $signed(xf[t_cnt][r_cnt]) * $signed(wk[r_cnt][c_cnt]);
        prod_v = $signed(xf[t_cnt][r_cnt]) * $signed(wv[r_cnt][c_cnt]);
        sum_q  = acc_q + ACC_W'(prod_q);
        sum_k  = acc_k + ACC_W'(prod_k);
        sum_v  = acc_v + ACC_W'(prod_v);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        ready_in  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                ready_in = 1'b1;
                if (valid_in) begin
                    state_nxt = MAC;
                end
            end
            MAC: begin
                busy = 1'b1;
                if (t_last && c_last && r_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (valid_out && ready_out) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Weight writes land only outside MAC so a frame always sees one consistent weight set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wq <= '0;
            wk <= '0;
            wv <= '0;
        end else if (w_we && (state != MAC)) begin
            case (w_sel)
                2'd0:    wq[w_row][w_col] <= w_data;
                2'd1:    wk[w_row][w_col] <= w_data;
                2'd2:    wv[w_row][w_col] <= w_data;
                default: ;
            endcase
        end
    end

    // Frame capture, counter walk (r inner, then c, then t) and result write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xf    <= '0;
            t_cnt <= '0;
            c_cnt <= '0;
            r_cnt <= '0;
            acc_q <= '0;
            acc_k <= '0;
            acc_v <= '0;
            Q     <= '0;
            K     <= '0;
            V     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        xf    <= X;
                        t_cnt <= '0;
                        c_cnt <= '0;
                        r_cnt <= '0;
                        acc_q <= '0;
                        acc_k <= '0;
                        acc_v <= '0;
                    end
                end
                MAC: begin
                    if (r_last) begin
                        Q[t_cnt][c_cnt] <= scale_sat(sum_q, bias_q_sel);
                        K[t_cnt][c_cnt] <= scale_sat(sum_k, bias_k_sel);
                        V[t_cnt][c_cnt] <= scale_sat(sum_v, bias_v_sel);
                        acc_q <= '0;
                        acc_k <= '0;
                        acc_v <= '0;
                        r_cnt <= '0;
                        if (c_last) begin
                            c_cnt <= '0;
                            t_cnt <= t_last ? '0 : t_cnt + TW'(1);
                        end else begin
                            c_cnt <= c_cnt + EW'(1);
                        end
                    end else begin
                        acc_q <= sum_q;
                        acc_k <= sum_k;
                        acc_v <= sum_v;
                        r_cnt <= r_cnt + EW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // valid_out rises one cycle into DONE and drops on the accepting ready_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
        end else if (state == DONE) begin
            if (!valid_out) begin
                valid_out <= 1'b1;
            end else if (ready_out) begin
                valid_out <= 1'b0;
            end
        end else begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qkv_proj_seq.sv
// Bench for qkv_proj_seq: randomized and directed frames checked against a plain-arithmetic model.
// The model recomputes X*W per frame from the weights the bench has committed.
// A single negedge compare process checks Q/K/V against the model whenever valid_out is high.
module tb_qkv_proj_seq;

    logic                    clk;
    logic                    rst_n;
    logic                    w_we;
    logic [1:0]              w_sel;
    logic [2:0]              w_row;
    logic [2:0]              w_col;
    logic [15:0]             w_data;
    logic                    valid_in;
    logic                    ready_in;
    logic [3:0][7:0][15:0]   x_bus;
    logic                    valid_out;
    logic                    ready_out;
    logic [3:0][7:0][15:0]   q_bus, k_bus, v_bus;
    logic                    busy;

    qkv_proj_seq dut (
        .clk(clk), .rst_n(rst_n),
        .w_we(w_we), .w_sel(w_sel), .w_row(w_row), .w_col(w_col), .w_data(w_data),
        .valid_in(valid_in), .ready_in(ready_in), .X(x_bus),
        .valid_out(valid_out), .ready_out(ready_out),
        .Q(q_bus), .K(k_bus), .V(v_bus), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cycle  = 0;
    int acc_cycle = 0;
    bit exp_armed = 1'b0;

    // Model state: committed weights, biases, current frame and expected outputs
    int mw [3][8][8];
    int mb [3][8];
    int xm [4][8];
    logic [3:0][7:0][15:0] exp_bus [3];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string nm, input longint got, input longint expv);
        n_chk++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, expv);
        end
    endtask

    task automatic cmp_bus(input string nm, input logic [3:0][7:0][15:0] got,
                           input logic [3:0][7:0][15:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            for (int t = 0; t < 4; t++)
                for (int c = 0; c < 8; c++)
                    if (got[t][c] !== expv[t][c]) begin
                        $display("FAIL %s[%0d][%0d] at cycle %0d: got %0d, expected %0d",
                                 nm, t, c, cycle, $signed(got[t][c]), $signed(expv[t][c]));
                        return;
                    end
        end
    endtask

    // Y[t][c] = clamp(floor(sum_r X[t][r]*W[r][c] / 256) + b[c])
    function automatic void model();
        for (int m = 0; m < 3; m++)
            for (int t = 0; t < 4; t++)
                for (int c = 0; c < 8; c++) begin
                    longint s = 0;
                    for (int r = 0; r < 8; r++)
                        s += longint'(xm[t][r]) * longint'(mw[m][r][c]);
                    s = s >>> 8;
                    s += mb[m][c];
                    if (s > 32767) s = 32767;
                    if (s < -32768) s = -32768;
                    exp_bus[m][t][c] = 16'(s);
                end
    endfunction

    // Whenever results are presented they must equal the model for the frame in flight
    always @(negedge clk) begin
        if (rst_n && exp_armed && valid_out) begin
            cmp_bus("Q", q_bus, exp_bus[0]);
            cmp_bus("K", k_bus, exp_bus[1]);
            cmp_bus("V", v_bus, exp_bus[2]);
        end
    end

    task automatic set_w(input int sel, input int row, input int col, input int val, input bit commit);
        @(negedge clk);
        w_we   = 1'b1;
        w_sel  = 2'(sel);
        w_row  = 3'(row);
        w_col  = 3'(col);
        w_data = 16'(val);
        @(negedge clk);
        w_we = 1'b0;
        if (commit) begin
            if (sel < 3) mw[sel][row][col] = val;
`ifdef QKV_PROJ_BIAS_EN
            else if (row < 3) mb[row][col] = val;
`endif
        end
    endtask

    // kind: 0 zero, 1 identity*256, 2 all 32767, 3 random full range, 4 random small
    task automatic load_all(input int kind);
        logic [15:0] rv;
        int v;
        for (int m = 0; m < 3; m++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) begin
                    rv = 16'($urandom);
                    case (kind)
                        0: v = 0;
                        1: v = (r == c) ? 256 : 0;
                        2: v = 32767;
                        3: v = int'($signed(rv));
                        default: v = int'($urandom_range(1023)) - 512;
                    endcase
                    set_w(m, r, c, v, 1'b1);
                end
    endtask

    task automatic rand_x(input bit full);
        logic [15:0] rv;
        for (int t = 0; t < 4; t++)
            for (int e = 0; e < 8; e++) begin
                rv = 16'($urandom);
                xm[t][e] = full ? int'($signed(rv)) : int'($urandom_range(4000)) - 2000;
            end
    endtask

    task automatic fill_x(input int val);
        for (int t = 0; t < 4; t++)
            for (int e = 0; e < 8; e++)
                xm[t][e] = val;
    endtask

    task automatic start_frame();
        @(negedge clk);
        for (int t = 0; t < 4; t++)
            for (int e = 0; e < 8; e++)
                x_bus[t][e] = 16'(xm[t][e]);
        model();
        exp_armed = 1'b1;
        chk("ready_in_idle", ready_in, 1);
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        acc_cycle = cycle;
        chk("busy_in_mac", busy, 1);
        chk("ready_in_mac", ready_in, 0);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!valid_out && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("valid_out_seen", valid_out, 1);
        chk("latency", cycle - acc_cycle, 257);
    endtask

    task automatic finish_frame();
        int n = 0;
        @(negedge clk);
        ready_out = 1'b1;
        while (!ready_in && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("back_to_idle", ready_in, 1);
        chk("valid_out_dropped", valid_out, 0);
    endtask

    task automatic run_frame();
        start_frame();
        wait_valid();
        finish_frame();
    endtask

    initial begin
        rst_n = 1'b0; w_we = 1'b0; w_sel = '0; w_row = '0; w_col = '0; w_data = '0;
        valid_in = 1'b0; ready_out = 1'b1; x_bus = '0;
        for (int m = 0; m < 3; m++)
            for (int i = 0; i < 8; i++) begin
                mb[m][i] = 0;
                for (int j = 0; j < 8; j++) mw[m][i][j] = 0;
            end

        // Reset state
        #12;
        chk("rst_ready_in", ready_in, 1);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_qkv_zero", {63'd0, |{q_bus, k_bus, v_bus}}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Identity projection: outputs equal X
        load_all(1);
        for (int t = 0; t < 4; t++)
            for (int e = 0; e < 8; e++)
                xm[t][e] = t * 8 + e - 10;
        start_frame();
        chk("model_identity", {63'd0, exp_bus[0] == x_bus}, 1);
        wait_valid();
        chk("ident_q00", q_bus[0][0], 16'hFFF6);
        chk("ident_k37", k_bus[3][7], 21);
        chk("ident_v12", v_bus[1][2], 0);
        finish_frame();

        // Randomized frames
        for (int i = 0; i < 3; i++) begin
            load_all(4);
            rand_x(i == 2);
            run_frame();
        end
        load_all(3);
        rand_x(1'b1);
        run_frame();

        // Saturation high and low
        load_all(2);
        fill_x(32767);
        start_frame();
        chk("model_sat_hi", exp_bus[1][1][1], 32767);
        wait_valid();
        chk("sat_hi_q25", q_bus[2][5], 32767);
        finish_frame();
        fill_x(-32768);
        start_frame();
        wait_valid();
        chk("sat_lo_v07", v_bus[0][7], 16'h8000);
        finish_frame();

        // Floor of a tiny negative value
        load_all(0);
        set_w(0, 0, 0, 1, 1'b1);
        fill_x(0);
        xm[0][0] = -1;
        start_frame();
        chk("model_floor", exp_bus[0][0][0], 16'hFFFF);
        wait_valid();
        chk("floor_q00", q_bus[0][0], 16'hFFFF);
        chk("floor_q01", q_bus[0][1], 0);
        finish_frame();

        // Backpressure: hold results, ignore a second frame offered in DONE
        load_all(4);
        rand_x(1'b0);
        ready_out = 1'b0;
        start_frame();
        wait_valid();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) begin
                x_bus = ~x_bus;
                valid_in = 1'b1;
            end
            if (i == 7) valid_in = 1'b0;
            @(posedge clk);
            #1;
            chk("bp_valid_held", valid_out, 1);
            chk("bp_ready_in_low", ready_in, 0);
        end
        finish_frame();
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_no_capture", busy, 0);
        end
        rand_x(1'b0);
        run_frame();

        // Write blocking in MAC, write in DONE used by the next frame
        load_all(4);
        rand_x(1'b0);
        ready_out = 1'b0;
        start_frame();
        set_w(0, 0, 0, 1000, 1'b0);
        wait_valid();
        set_w(0, 0, 0, 1000, 1'b1);
        finish_frame();
        start_frame();
        chk("model_wq00", mw[0][0][0], 1000);
        wait_valid();
        finish_frame();

        // Reset in the middle of MAC clears everything, weights included
        rand_x(1'b0);
        start_frame();
        repeat (99) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid_out", valid_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready_in", ready_in, 1);
        chk("midrst_qkv_zero", {63'd0, |{q_bus, k_bus, v_bus}}, 0);
        for (int m = 0; m < 3; m++)
            for (int i = 0; i < 8; i++) begin
                mb[m][i] = 0;
                for (int j = 0; j < 8; j++) mw[m][i][j] = 0;
            end
        @(negedge clk);
        rst_n = 1'b1;
        rand_x(1'b1);
        run_frame();

        // Bias write: effective only when bias storage is built in
        load_all(1);
        set_w(3, 0, 3, 5, 1'b1);
        fill_x(0);
        start_frame();
        wait_valid();
`ifdef QKV_PROJ_BIAS_EN
        chk("bias_q23", q_bus[2][3], 5);
`else
        chk("bias_q23", q_bus[2][3], 0);
`endif
        chk("bias_q22", q_bus[2][2], 0);
        finish_frame();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
